// File: rtl/tank_level_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tank_level_reader_pkg
//  Purpose  : Shared level encodings, FSM state encoding and the sensor
//             pattern decoder used by the tank level reader.
//  Revision : 1.0  initial release
// ============================================================================
package tank_level_reader_pkg;

    localparam logic [1:0] LEVEL_EMPTY = 2'b00;
    localparam logic [1:0] LEVEL_LOW   = 2'b01;
    localparam logic [1:0] LEVEL_MID   = 2'b10;
    localparam logic [1:0] LEVEL_HIGH  = 2'b11;

    typedef enum logic [1:0] {
        WAIT  = 2'b00,
        VALID = 2'b01,
        FAULT = 2'b10
    } state_t;

    typedef struct packed {
        logic       consistent;
        logic [1:0] level;
    } decode_t;

    // Probes are wetted bottom-up, so only thermometer patterns are physical.
    function automatic decode_t decode_pattern(input logic [2:0] pattern);
        decode_t result;
        result.consistent = 1'b1;
        result.level      = LEVEL_EMPTY;
        case (pattern)
            3'b000:  result.level = LEVEL_EMPTY;
            3'b001:  result.level = LEVEL_LOW;
            3'b011:  result.level = LEVEL_MID;
            3'b111:  result.level = LEVEL_HIGH;
            default: result.consistent = 1'b0;
        endcase
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tank_level_reader_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : 1-bit two-stage synchronizer with asynchronous active-high
//             reset, for bringing a probe flag into the clock domain.
//  Revision : 1.0  initial release
// ============================================================================
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two flops in series; the first may go metastable, the second settles it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/tank_level_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tank_level_reader
//  Purpose  : Synchronizes three tank probes, debounces the combined pattern
//             and reports an accepted level, validity, fault and a change
//             pulse, all from registers.
//  Revision : 1.0  initial release
// ============================================================================
module tank_level_reader
    import tank_level_reader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sensor_low,
    input  logic       sensor_mid,
    input  logic       sensor_high,
    output logic [1:0] level,
    output logic       level_valid,
    output logic       fault,
    output logic       changed
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0] sensor_raw;
    logic [2:0] sample;

    assign sensor_raw = {sensor_high, sensor_mid, sensor_low};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        sync_2ff u_sync (
            .clock (clock),
            .reset (reset),
            .d_i   (sensor_raw[gi]),
            .q_o   (sample[gi])
        );
    end

    // ------------------------------------------------------------------
    // Debounce: candidate pattern, stability counter and a flag that
    // limits acceptance to one event per stable period.
    // ------------------------------------------------------------------
    logic [2:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             accept;

    // Debounce state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cand_q <= 3'b000;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // Restart on any differing sample, count while stable, accept once at saturation.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        accept = 1'b0;
        if (sample != cand_q) begin
            cand_d = sample;
            cnt_d  = '0;
            done_d = 1'b0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!done_q) begin
            accept = 1'b1;
            done_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output FSM. Outputs are held in registers alongside the state so
    // they update on the same edge as the accept.
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [1:0] level_q, level_d;
    logic       valid_q, valid_d;
    logic       fault_q, fault_d;
    logic       changed_q, changed_d;
    decode_t    dec;

    // On an accept edge the candidate equals the current sample.
    assign dec = decode_pattern(cand_q);

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= WAIT;
            level_q   <= LEVEL_EMPTY;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
            changed_q <= changed_d;
        end
    end

    // Next state and outputs; change pulses only when something visible moves.
    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        valid_d   = valid_q;
        fault_d   = fault_q;
        changed_d = 1'b0;
        if (accept) begin
            if (dec.consistent) begin
                state_d   = VALID;
                level_d   = dec.level;
                valid_d   = 1'b1;
                fault_d   = 1'b0;
                changed_d = (state_q != VALID) || (level_q != dec.level);
            end else begin
                state_d   = FAULT;
                valid_d   = 1'b0;
                fault_d   = 1'b1;
                changed_d = (state_q != FAULT);
            end
        end
    end

    assign level       = level_q;
    assign level_valid = valid_q;
    assign fault       = fault_q;
    assign changed     = changed_q;

endmodule
`default_nettype wire

// File: doc/tank_level_reader.md
TANK_LEVEL_READER -- requirements
Module: tank_level_reader

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized samples required before a sensor pattern is accepted (legal range 1..255).
REQ-002 SHALL have port clock  input  1  rising-edge system clock.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port sensor_low  input  1  low-probe wet flag, asynchronous to clock.
REQ-005 SHALL have port sensor_mid  input  1  mid-probe wet flag, asynchronous to clock.
REQ-006 SHALL have port sensor_high  input  1  high-probe wet flag, asynchronous to clock.
REQ-007 SHALL have port level  output  2  accepted tank level: 00 empty, 01 low, 10 mid, 11 high.
REQ-008 SHALL have port level_valid  output  1  high while the accepted pattern is consistent.
REQ-009 SHALL have port fault  output  1  high while the accepted pattern is inconsistent.
REQ-010 SHALL have port changed  output  1  one-cycle pulse on every update of level or level_valid.

Function
REQ-011 SHALL pass each sensor input through a two-stage synchronizer; the second stage forms the 3-bit sample s = {high, mid, low}.
REQ-012 SHALL hold a candidate register c and a counter cnt; on each edge, if s != c then c <= s and cnt <= 0; otherwise, if cnt < DEBOUNCE_CYCLES-1, cnt increments; otherwise cnt saturates.
REQ-013 SHALL generate an accept event on the single edge where s == c and cnt == DEBOUNCE_CYCLES-1; there is one accept per stable period, and no further accept occurs while cnt stays saturated.
REQ-014 SHALL treat patterns 000, 001, 011 and 111 as consistent, mapping to level 00, 01, 10 and 11 respectively; all other patterns are inconsistent.
REQ-015 SHALL implement the FSM states WAIT, VALID and FAULT.
REQ-016 WAIT is the reset state; outputs level=00, level_valid=0, fault=0.
REQ-017 On accept of a consistent pattern from any state, SHALL go to VALID, load level, set level_valid=1 and fault=0.
REQ-018 On accept of an inconsistent pattern from any state, SHALL go to FAULT, set fault=1 and level_valid=0, and hold level at its last value.
REQ-019 SHALL pulse changed for exactly one cycle, coincident with the output update, on: WAIT->VALID, WAIT->FAULT, VALID<->FAULT, or a VALID->VALID accept with a different level.
REQ-020 SHALL NOT pulse changed on a VALID->VALID accept with the same level, or on a FAULT->FAULT accept.
REQ-021 SHALL update outputs exactly DEBOUNCE_CYCLES+3 rising edges after an input change that then remains stable.
REQ-022 SHALL restart debounce on any sample differing from c, including single-cycle glitches; outputs stay unchanged.
REQ-023 All outputs SHALL be registered, with no combinational path from the sensor inputs to the outputs.

Reset
REQ-024 Reset SHALL immediately clear the synchronizer stages to 0, c to 000, cnt to 0 and state to WAIT.
REQ-025 Reset SHALL immediately drive level=00, level_valid=0, fault=0 and changed=0.
REQ-026 Reset asserted mid-debounce or mid-pulse SHALL abort it; after release, behaviour SHALL restart from WAIT.

Structure
REQ-027 A shared package SHALL hold the level encodings (LEVEL_EMPTY, LEVEL_LOW, LEVEL_MID, LEVEL_HIGH) and the FSM state encoding (WAIT, VALID, FAULT).
REQ-028 The counter width SHALL be derived from DEBOUNCE_CYCLES with $clog2, minimum 1 bit.
REQ-029 One sub-module, sync_2ff (1-bit two-stage synchronizer with asynchronous reset), SHALL be instantiated once per sensor input.

Verification
REQ-030 Run with DEBOUNCE_CYCLES=4: reset, release, then drive 001 -> at edge 7 expect level=01, level_valid=1, fault=0, changed=1 for one cycle.
REQ-031 From VALID level 01, drive 011 and then glitch 001 for one cycle at edge 3 -> no output change until 7 edges after the glitch ends, then level=10 with a changed pulse.
REQ-032 From VALID, drive 101 -> after 7 edges expect fault=1, level_valid=0, level held at its previous value, changed pulse; then drive 111 -> after 7 edges expect level=11, fault=0, level_valid=1, changed pulse.
REQ-033 Hold 011 stable for 50 cycles -> exactly one changed pulse, and level stays 10.
REQ-034 Assert reset at debounce edge 5 of a 111 transition -> outputs immediately 00/0/0/0; after release with 111 still applied, level=11 after 7 edges.
REQ-035 Run with DEBOUNCE_CYCLES=1: drive 000 -> 001 -> outputs update 4 edges after the change.
